// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared sizes, state encoding and row packing helper
// for the systolic array host adapter.
package systolic_pkg;

   localparam int N      = 4;
   localparam int ELEM_W = 8;
   localparam int ACC_W  = 32;
   localparam int ROW_W  = N * ELEM_W;
   localparam int MAT_W  = N * ROW_W;
   localparam int RES_W  = N * N * ACC_W;

   typedef enum logic [2:0] {LOAD, START, WAIT, DRAIN, CLEAR} host_state_t;

   // Row 0 sits in the most significant bits of a packed matrix.
   function automatic int row_lsb(input logic [1:0] idx);
      return MAT_W - ROW_W * (int'(idx) + 1);
   endfunction

endpackage

// File: rtl/result_serializer.sv
// rtl/result_serializer.sv - holds one 4x4 int32 result and streams it out
// row-major as sixteen 32-bit words with valid/ready/last.
module result_serializer
   import systolic_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [RES_W-1:0] data_i,
   input  logic             m_ready_i,
   output logic             m_valid_o,
   output logic [ACC_W-1:0] m_data_o,
   output logic             m_last_o,
   output logic             done_o
);

   logic [RES_W-1:0] hold_q;
   logic [3:0]       idx_q;
   logic             valid_q;
   logic             hs;
   logic [ACC_W-1:0] elems [N*N];

   assign hs = valid_q && m_ready_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else if (load_i) begin
         hold_q  <= data_i;
         idx_q   <= '0;
         valid_q <= 1'b1;
      end else if (hs) begin
         if (idx_q == 4'd15) valid_q <= 1'b0;
         idx_q <= idx_q + 4'd1;
      end
   end

   // C[0][0] occupies the top word of the hold register.
   always_comb begin
      for (int i = 0; i < N*N; i++) elems[i] = hold_q[RES_W - ACC_W*(i+1) +: ACC_W];
   end

   assign m_valid_o = valid_q;
   assign m_data_o  = elems[idx_q];
   assign m_last_o  = valid_q && (idx_q == 4'd15);
   assign done_o    = hs && (idx_q == 4'd15);

endmodule

// File: rtl/systolic_host_adapter.sv
// rtl/systolic_host_adapter.sv - loads A/B from a word stream, starts the
// array, drains its results and clears it, with a timeout on completion.
module systolic_host_adapter
   import systolic_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CLEAR_CYCLES   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [ROW_W-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [ACC_W-1:0] m_data,
   output logic             m_last,
   output logic             valid_in,
   output logic [MAT_W-1:0] matrix_A,
   output logic [MAT_W-1:0] matrix_B,
   input  logic [RES_W-1:0] y,
   input  logic             done_matrix_mult,
   output logic             mac_clear,
   output logic             busy,
   output logic             error
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CW = $clog2(CLEAR_CYCLES + 1);

   host_state_t      state_q;
   logic [2:0]       word_cnt_q;
   logic [TW-1:0]    tmo_cnt_q;
   logic [CW-1:0]    clr_cnt_q;
   logic [MAT_W-1:0] matrix_a_q, matrix_b_q;
   logic             valid_in_q, mac_clear_q, error_q;
   logic             ser_load, ser_done;

   assign ser_load = (state_q == WAIT) && done_matrix_mult;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= LOAD;
         word_cnt_q  <= '0;
         tmo_cnt_q   <= '0;
         clr_cnt_q   <= '0;
         matrix_a_q  <= '0;
         matrix_b_q  <= '0;
         valid_in_q  <= 1'b0;
         mac_clear_q <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         valid_in_q <= 1'b0;
         case (state_q)
            LOAD: if (s_valid) begin
               if (word_cnt_q == 3'd0) error_q <= 1'b0;
               if (!word_cnt_q[2]) matrix_a_q[row_lsb(word_cnt_q[1:0]) +: ROW_W] <= s_data;
               else                matrix_b_q[row_lsb(word_cnt_q[1:0]) +: ROW_W] <= s_data;
               word_cnt_q <= word_cnt_q + 3'd1;
               if (word_cnt_q == 3'd7) begin
                  state_q    <= START;
                  valid_in_q <= 1'b1;
               end
            end
            START: begin
               tmo_cnt_q <= '0;
               state_q   <= WAIT;
            end
            WAIT: if (done_matrix_mult) begin
               state_q <= DRAIN;
            end else begin
               tmo_cnt_q <= tmo_cnt_q + 1'b1;
               if (tmo_cnt_q + 1'b1 == TW'(TIMEOUT_CYCLES)) begin
                  error_q     <= 1'b1;
                  state_q     <= CLEAR;
                  mac_clear_q <= 1'b1;
                  clr_cnt_q   <= '0;
               end
            end
            DRAIN: if (ser_done) begin
               state_q     <= CLEAR;
               mac_clear_q <= 1'b1;
               clr_cnt_q   <= '0;
            end
            CLEAR: if (clr_cnt_q == CW'(CLEAR_CYCLES - 1)) begin
               state_q     <= LOAD;
               mac_clear_q <= 1'b0;
            end else begin
               clr_cnt_q <= clr_cnt_q + 1'b1;
            end
            default: state_q <= LOAD;
         endcase
      end
   end

   result_serializer u_ser (
      .clk       (clk),
      .reset     (reset),
      .load_i    (ser_load),
      .data_i    (y),
      .m_ready_i (m_ready),
      .m_valid_o (m_valid),
      .m_data_o  (m_data),
      .m_last_o  (m_last),
      .done_o    (ser_done)
   );

   assign s_ready   = (state_q == LOAD);
   assign busy      = (state_q != LOAD);
   assign valid_in  = valid_in_q;
   assign mac_clear = mac_clear_q;
   assign error     = error_q;
   assign matrix_A  = matrix_a_q;
   assign matrix_B  = matrix_b_q;

endmodule

// File: tb/tb_systolic_host_adapter.sv
// tb/tb_systolic_host_adapter.sv - directed and random jobs against a
// behavioural array stub and matrix-product reference model.
module tb_systolic_host_adapter;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [31:0]  s_data = '0;
   logic         m_valid;
   logic         m_ready = 1'b1;
   logic [31:0]  m_data;
   logic         m_last;
   logic         valid_in;
   logic [127:0] matrix_A, matrix_B;
   logic [511:0] y = '0;
   logic         done_matrix_mult = 1'b0;
   logic         mac_clear;
   logic         busy;
   logic         error;

   int checks = 0;
   int errors = 0;
   bit stub_en = 1'b1;
   bit pend = 1'b0;
   int unsigned stub_cnt = 0;
   logic first_err;

   always #5 clk = ~clk;

   systolic_host_adapter #(.TIMEOUT_CYCLES(64), .CLEAR_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .valid_in(valid_in), .matrix_A(matrix_A), .matrix_B(matrix_B), .y(y),
      .done_matrix_mult(done_matrix_mult), .mac_clear(mac_clear), .busy(busy), .error(error)
   );

   function automatic logic [511:0] array_mult(input logic [127:0] a, input logic [127:0] b);
      logic [511:0] r = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            int acc = 0;
            for (int k = 0; k < 4; k++)
               acc += int'($signed(a[127-32*i-8*k -: 8])) * int'($signed(b[127-32*k-8*j -: 8]));
            r[511-32*(4*i+j) -: 32] = acc;
         end
      return r;
   endfunction

   // Array stand-in: done is sticky until its reset (system reset or mac_clear).
   always @(negedge clk) begin
      if (reset || mac_clear) begin
         done_matrix_mult = 1'b0;
         y = '0;
         pend = 1'b0;
      end else if (stub_en) begin
         if (valid_in) begin
            pend = 1'b1;
            stub_cnt = $urandom_range(0, 8);
         end else if (pend) begin
            if (stub_cnt == 0) begin
               y = array_mult(matrix_A, matrix_B);
               done_matrix_mult = 1'b1;
               pend = 1'b0;
            end else stub_cnt--;
         end
      end
   end

   function automatic void model(input logic [31:0] w[8], output logic [31:0] e[16]);
      int a[4][4];
      int b[4][4];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            logic [7:0] ba, bb;
            ba = w[r][31-8*c -: 8];
            bb = w[4+r][31-8*c -: 8];
            a[r][c] = int'($signed(ba));
            b[r][c] = int'($signed(bb));
         end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            int s = 0;
            for (int k = 0; k < 4; k++) s += a[i][k] * b[k][j];
            e[4*i+j] = s;
         end
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_job(input logic [31:0] w[8]);
      for (int n = 0; n < 8; n++) begin
         int b = 0;
         s_valid = 1'b1;
         s_data  = w[n];
         while (!s_ready && b < 300) begin tick; b++; end
         if (b >= 300) chk("s_ready_timeout", 0, 1);
         tick;
         if (n == 0) first_err = error;
      end
      s_valid = 1'b0;
   endtask

   task automatic collect(input int pat, input logic [31:0] e[16], input int stop_at);
      int n = 0, cyc = 0, phase = 0;
      bit stalled = 1'b0;
      logic [31:0] held = '0;
      while (n < 16 && cyc < 600) begin
         if (n == stop_at) break;
         m_ready = (pat == 0) ? 1'b1 : ((phase % 4 == 0) || (phase % 4 == 3));
         phase++;
         if (stalled) chk("stall_hold", m_data, held);
         if (m_valid) begin
            if (m_ready) begin
               chk($sformatf("data_k%0d", n), m_data, e[n]);
               chk($sformatf("last_k%0d", n), m_last, (n == 15));
               n++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held = m_data;
            end
         end
         tick;
         cyc++;
      end
      m_ready = 1'b1;
      if (stop_at > 15) begin
         chk("handshakes", n, 16);
         chk("m_valid_after_drain", m_valid, 0);
      end
   endtask

   task automatic measure_clear;
      int hi = 0, cyc = 0;
      while (!s_ready && cyc < 100) begin
         if (mac_clear) hi++;
         tick;
         cyc++;
      end
      chk("mac_clear_cycles", hi, 2);
      chk("s_ready_back", s_ready, 1);
   endtask

   task automatic chk_reset_vals;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_valid_in", valid_in, 0);
      chk("rst_mac_clear", mac_clear, 0);
      chk("rst_error", error, 0);
      chk("rst_busy", busy, 0);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_matrix_A", matrix_A[63:0] | matrix_A[127:64], 0);
      chk("rst_matrix_B", matrix_B[63:0] | matrix_B[127:64], 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w[8];
      logic [31:0] w2[8];
      logic [31:0] e[16];
      logic [31:0] e2[16];
      logic [31:0] exp_q[$];
      int waitc, mv, cyc, idx, n, bad, late;

      // Reset state
      tick; tick; tick;
      chk_reset_vals();
      reset = 1'b0;
      tick;
      chk("s_ready_after_reset", s_ready, 1);

      // Identity A times B
      w = '{32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001,
            32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
      for (int i = 0; i < 16; i++) e[i] = i + 1;
      send_job(w);
      chk("valid_in_pulse", valid_in, 1);
      chk("s_ready_low_in_start", s_ready, 0);
      chk("busy_in_start", busy, 1);
      chk("matrix_A_hi", matrix_A[127:64], {w[0], w[1]});
      chk("matrix_A_lo", matrix_A[63:0], {w[2], w[3]});
      chk("matrix_B_hi", matrix_B[127:64], {w[4], w[5]});
      chk("matrix_B_lo", matrix_B[63:0], {w[6], w[7]});
      tick;
      chk("valid_in_one_cycle", valid_in, 0);
      collect(0, e, 99);
      measure_clear();

      // All -128
      for (int i = 0; i < 8; i++) w[i] = 32'h80808080;
      for (int i = 0; i < 16; i++) e[i] = 32'h00010000;
      send_job(w);
      collect(0, e, 99);
      chk("error_neg128", error, 0);
      measure_clear();

      // Same job with back-pressure 1-0-0-1
      send_job(w);
      collect(1, e, 99);
      measure_clear();

      // Timeout: array never completes
      stub_en = 1'b0;
      for (int i = 0; i < 8; i++) w[i] = $urandom;
      send_job(w);
      waitc = 0; mv = 0; cyc = 0;
      tick;
      while (!mac_clear && cyc < 300) begin
         if (m_valid) mv++;
         waitc++;
         tick;
         cyc++;
      end
      chk("timeout_wait_cycles", waitc, 64);
      chk("timeout_no_m_valid", mv, 0);
      chk("timeout_error_set", error, 1);
      measure_clear();
      chk("error_sticky_in_load", error, 1);
      stub_en = 1'b1;
      for (int i = 0; i < 8; i++) w[i] = $urandom;
      model(w, e);
      send_job(w);
      chk("error_cleared_first_word", first_err, 0);
      collect(1, e, 99);
      measure_clear();

      // Reset mid-drain at index 7
      for (int i = 0; i < 8; i++) w[i] = $urandom;
      model(w, e);
      send_job(w);
      collect(0, e, 7);
      chk("at_drain_k7", m_valid, 1);
      reset = 1'b1;
      tick;
      chk_reset_vals();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) w[i] = $urandom;
      model(w, e);
      send_job(w);
      collect(0, e, 99);
      measure_clear();

      // Back-to-back jobs with s_valid held high
      for (int i = 0; i < 8; i++) begin w[i] = $urandom; w2[i] = $urandom; end
      model(w, e);
      model(w2, e2);
      for (int i = 0; i < 16; i++) exp_q.push_back(e[i]);
      for (int i = 0; i < 16; i++) exp_q.push_back(e2[i]);
      idx = 0; n = 0; cyc = 0; bad = 0; late = 0;
      m_ready = 1'b1;
      while (n < 32 && cyc < 3000) begin
         s_valid = (idx < 16);
         s_data  = (idx < 8) ? w[idx % 8] : w2[idx % 8];
         if (s_ready && (busy || valid_in || mac_clear || m_valid)) bad++;
         if (m_valid) begin
            if (exp_q.size() > 0) begin
               chk($sformatf("b2b_k%0d", n), m_data, exp_q.pop_front());
            end else late++;
            n++;
         end
         if (s_valid && s_ready) idx++;
         tick;
         cyc++;
      end
      s_valid = 1'b0;
      chk("b2b_outputs", n, 32);
      chk("b2b_words_accepted", idx, 16);
      chk("b2b_no_accept_while_busy", bad, 0);
      chk("b2b_no_extra_words", late, 0);
      measure_clear();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
